// File: rtl/t_stream_buffer_pkg.sv
// t_stream_buffer_pkg: shared sizes and FSM encoding for the target-sequence stream buffer.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif
`ifndef TBUF_DEPTH
`define TBUF_DEPTH 1024
`endif
`ifndef TBUF_LEN_BITS
`define TBUF_LEN_BITS 10
`endif
package t_stream_buffer_pkg;
  localparam int DEF_VEF_BITS = `V_E_F_Bit;
  localparam int DEF_DEPTH    = `TBUF_DEPTH;
  localparam int DEF_LEN_BITS = `TBUF_LEN_BITS;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    READY  = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_e;
endpackage

// File: rtl/tbuf_mem.sv
// tbuf_mem: entry store with one synchronous write port and one registered, resettable read port.
module tbuf_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int W     = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/t_stream_buffer.sv
// t_stream_buffer: holds T plus per-symbol (v,f), streams it to the PE array and captures the write-back.
// Optional TBUF_MAX_TRACK_EN adds o_max_v, the running max of accepted write-back v.
module t_stream_buffer
  import t_stream_buffer_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LEN_BITS = DEF_LEN_BITS,
  parameter int VEF_BITS = DEF_VEF_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load_valid,
  input  logic [1:0]          i_load_t,
  input  logic                i_load_last,
  input  logic                i_pass_start,
  input  logic                i_first_pass,
  input  logic                i_no_wb,
  input  logic                i_clear,
  output logic                o_t_valid,
  input  logic                i_t_pop,
  output logic [1:0]          o_t,
  output logic [VEF_BITS-1:0] o_v,
  output logic [VEF_BITS-1:0] o_f,
  output logic                o_t_last,
  input  logic                i_wb_valid,
  input  logic [1:0]          i_wb_t,
  input  logic [VEF_BITS-1:0] i_wb_v,
  input  logic [VEF_BITS-1:0] i_wb_f,
  input  logic                i_wb_last,
  output logic [LEN_BITS-1:0] o_len,
  output logic                o_busy,
  output logic                o_pass_done,
  output logic                o_err
`ifdef TBUF_MAX_TRACK_EN
  ,
  output logic [VEF_BITS-1:0] o_max_v
`endif
);
  localparam int W = 2 + 2 * VEF_BITS;
  localparam logic [LEN_BITS:0]   FULL = (LEN_BITS+1)'(DEPTH);
  localparam logic [LEN_BITS-1:0] LAST = LEN_BITS'(DEPTH - 1);
  state_e state;
  logic [LEN_BITS:0] wr_ptr, popped;
  logic [LEN_BITS-1:0] rd_ptr, mem_raddr;
  logic first, skip_wb, wb_seen;
  logic load_ok, ld_wr, clr, pass_go, pop, pop_last, wb_on, wb_wr, mem_we, mem_re;
  logic [W-1:0] mem_wdata, rdata;
  logic [1:0] rd_t;
  logic [VEF_BITS-1:0] rd_v, rd_f;
  always_comb begin
    load_ok   = i_load_valid && (state == IDLE || state == LOAD);
    ld_wr     = load_ok && wr_ptr != FULL;
    clr       = state == READY && i_clear;
    pass_go   = state == READY && i_pass_start && !i_clear;
    pop       = state == STREAM && o_t_valid && i_t_pop;
    pop_last  = pop && rd_ptr == o_len;
    wb_on     = i_wb_valid && !skip_wb && (state == STREAM || state == DRAIN);
    // only slots already handed to the array may be overwritten
    wb_wr     = wb_on && wr_ptr < popped;
    mem_we    = ld_wr || wb_wr;
    mem_wdata = ld_wr ? {i_load_t, {(2*VEF_BITS){1'b0}}} : {i_wb_t, i_wb_v, i_wb_f};
    mem_re    = pass_go || (pop && !pop_last);
    mem_raddr = pass_go ? '0 : rd_ptr + 1'b1;
  end
  tbuf_mem #(.DEPTH(DEPTH), .AW(LEN_BITS), .W(W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_ptr[LEN_BITS-1:0]),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rdata)
  );
  assign {rd_t, rd_v, rd_f} = rdata;
  assign o_t      = rd_t;
  assign o_v      = first ? '0 : rd_v;
  assign o_f      = first ? '0 : rd_f;
  assign o_t_last = o_t_valid && rd_ptr == o_len;
  assign o_busy   = state == LOAD || state == STREAM || state == DRAIN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      popped      <= '0;
      o_len       <= '0;
      o_err       <= 1'b0;
      o_t_valid   <= 1'b0;
      o_pass_done <= 1'b0;
      first       <= 1'b0;
      skip_wb     <= 1'b0;
      wb_seen     <= 1'b0;
    end else begin
      o_pass_done <= 1'b0;
      if (mem_we) wr_ptr <= wr_ptr + 1'b1;
      if ((load_ok && !ld_wr) || (wb_on && !wb_wr)) o_err <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        popped <= popped + 1'b1;
      end
      case (state)
        IDLE, LOAD:
          if (load_ok) begin
            state <= i_load_last ? READY : LOAD;
            if (i_load_last) o_len <= ld_wr ? wr_ptr[LEN_BITS-1:0] : LAST;
          end
        READY:
          if (clr) begin
            state  <= IDLE;
            wr_ptr <= '0;
          end else if (pass_go) begin
            state     <= STREAM;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            popped    <= '0;
            first     <= i_first_pass;
            skip_wb   <= i_no_wb;
            wb_seen   <= 1'b0;
            o_t_valid <= 1'b1;
          end
        STREAM: begin
          if (wb_on && i_wb_last) wb_seen <= 1'b1;
          if (pop_last) begin
            o_t_valid <= 1'b0;
            // an early wb_last is honoured once the final entry has left
            if (skip_wb || wb_seen || (wb_on && i_wb_last)) begin
              state       <= READY;
              o_pass_done <= 1'b1;
            end else state <= DRAIN;
          end
        end
        DRAIN:
          if (wb_on && i_wb_last) begin
            state       <= READY;
            o_pass_done <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef TBUF_MAX_TRACK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_max_v <= '0;
    else if (clr) o_max_v <= '0;
    else if (wb_wr && i_wb_v > o_max_v) o_max_v <= i_wb_v;
`endif
endmodule
